// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache<->memory strobe protocol: latches a request on
// MStrobe and completes it with a one-cycle MReady pulse after WAIT_CYCLES edges.
module main_memory_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MStrobe,
   input  logic              MRW,
   input  logic [ADDR_W-1:0] MAddr,
   input  logic [DATA_W-1:0] MDataIn,
   output logic [DATA_W-1:0] MDataOut,
   output logic              MReady,
   output logic              MBusy,
   output logic              MOverrun
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              enter_done;
   logic              accept;

   logic [DATA_W-1:0] mem [Depth];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_done = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (MStrobe) begin
               accept  = 1'b1;
               state_d = StWait;
               cnt_d   = 8'(WAIT_CYCLES - 1);
            end
         end
         StWait: begin
            // The completing edge is the one that sees the count already at zero.
            if (cnt_q == 8'd0) begin
               state_d    = StDone;
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= 8'd0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         MDataOut <= '0;
         MOverrun <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rw_q   <= MRW;
            addr_q <= MAddr;
            data_q <= MDataIn;
         end
         if (enter_done && !rw_q) begin
            MDataOut <= mem[addr_q];
         end
         if (MStrobe && state_q != StIdle) begin
            MOverrun <= 1'b1;
         end
      end
   end

   // Backing array is not reset; a write interrupted by reset is never committed.
   always_ff @(posedge clk) begin
      if (!reset && enter_done && rw_q) begin
         mem[addr_q] <= data_q;
      end
   end

   assign MReady = (state_q == StDone);
   assign MBusy  = (state_q != StIdle);

endmodule
